simplebus_sram_responder: RTL and testbench
===========================================

Name: simplebus_sram_responder

Overview:
- Responder (slave) end of the SimpleBus request/response interface that IFU and LSU use as initiators.
- Replaces the ad-hoc counter-plus-DPI memory model in the top level with a synthesizable word-addressed SRAM.
- Has a programmable response latency and full valid/ready handshakes on both the request and response channels.
- One instance per initiator port (IFU fetch, LSU data).

Parameters:
- ADDR_BASE, 32'h8000_0000: byte address that maps to word 0.
- DEPTH_WORDS, 4096: number of 32-bit words; must be a power of two, at least 2.
- LATENCY, 2: fixed wait cycles between request accept and memory access; legal range 0..15.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-low reset.
- req_valid, input, 1: initiator presents a request.
- req_ready, output, 1: responder can accept a request.
- req_addr, input, 32: byte address; bits [1:0] ignored.
- req_wen, input, 1: 1 = write, 0 = read.
- req_wdata, input, 32: write data.
- req_wmask, input, 4: byte-lane write enables; bit i covers bits [8i+7:8i].
- resp_valid, output, 1: response available.
- resp_ready, input, 1: initiator accepts the response.
- resp_rdata, output, 32: read data; 0 for writes and errors.
- resp_err, output, 1: address outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS).

Behaviour:
- Reset: rst is synchronous, active-low; clock clk.
  - While rst=0 at an edge: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - SRAM contents are not reset.
  - req_ready becomes 1 in the first cycle after rst returns high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid && req_ready at edge T. Latch addr, wen, wdata and wmask.
  - If LATENCY==0: perform the access at edge T and go to RESP.
  - Otherwise: load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter==0: perform the access and go to RESP. Otherwise decrement counter.
- Latency: resp_valid is high in the cycle after edge T+LATENCY. Minimum is 1 cycle after accept.
- Access, with word index = (addr-ADDR_BASE)>>2 computed in 32-bit unsigned arithmetic:
  - In-range read: resp_rdata = mem[index], resp_err=0.
  - In-range write: bytes with wmask=1 are updated; other bytes are unchanged; resp_rdata=0; resp_err=0.
  - wmask=4'b0000 write: memory is unchanged and the response is still returned.
  - Out of range (including addr < ADDR_BASE, detected by wrap): no memory change, resp_rdata=0, resp_err=1.
- RESP:
  - req_ready=0.
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid && resp_ready: go to IDLE, and resp_valid drops next cycle.
  - There is no request accept in the handshake cycle. Maximum throughput is one transaction per LATENCY+2 cycles.
- Requests are never dropped: req_valid may be held high arbitrarily long; only the accept edge samples it.
- Request fields after accept are don't-care; latched copies are used.
- Reset mid-operation: FSM returns to IDLE.
  - A write still in WAIT is never applied.
  - A write already performed stays in memory.
  - A pending response is discarded.
- Same-address write then read returns the newly written data; no bypass is needed because accesses are serialized.

Optional Feature:
- Macro: SIMPLEBUS_RAND_DELAY_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle.
  - On accept, the effective latency is LATENCY + lfsr[1:0], range LATENCY..LATENCY+3.
  - This is used to stress initiator handshakes.
- When undefined: latency is exactly LATENCY, and no LFSR logic exists.

Decomposition:
- Package simplebus_pkg holds:
  - FSM state enum (IDLE, WAIT, RESP).
  - SB_ADDR_W=32, SB_DATA_W=32, SB_MASK_W=4.
  - Default ADDR_BASE constant.
  - LFSR seed 16'hACE1.
- One natural sub-module: simplebus_lfsr16, instantiated only under SIMPLEBUS_RAND_DELAY_EN.
- The SRAM array stays inline as a behavioural register array.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release -> resp_valid=0 throughout; req_ready=1 from the first cycle after release.
- Write then read, LATENCY=2, resp_ready=1:
  - Write 0x8000_0010 data 0xDEADBEEF mask 4'hF -> resp_valid high exactly after edge T+2, rdata=0, err=0.
  - Read 0x8000_0010 -> rdata=0xDEADBEEF.
- Byte mask: with word 0x8000_0010=0xDEADBEEF, write 0x0000_0055 mask 4'b0001, then read -> 0xDEADBE55. Mask 4'b0000 write leaves 0xDEADBE55.
- Backpressure: read with resp_ready=0 for 5 cycles -> resp_valid, rdata and err stay stable and req_ready=0; after resp_ready=1 handshake, resp_valid=0 next cycle.
- Out of range: read 0x7FFF_FFFC and write 0x8000_4000 (DEPTH_WORDS=4096) -> err=1, rdata=0; a following read of 0x8000_0000 shows it unchanged.
- Reset mid-WAIT with LATENCY=4: accept a write to 0x8000_0020 of 0x12345678, assert rst=0 one cycle later -> after reset, no response is seen, and reading 0x8000_0020 returns its prior value.

Source files
------------

// File: rtl/simplebus_pkg.sv
// simplebus_pkg: shared SimpleBus widths, default address map, responder FSM states and LFSR seed
package simplebus_pkg;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_MASK_W = 4;
  localparam logic [SB_ADDR_W-1:0] SB_ADDR_BASE = 32'h8000_0000;
  localparam logic [15:0] SB_LFSR_SEED = 16'hACE1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} sb_state_e;
endpackage

// File: rtl/simplebus_lfsr16.sv
// simplebus_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on active-low sync reset
module simplebus_lfsr16
  import simplebus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= SB_LFSR_SEED;
    else q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/simplebus_sram_responder.sv
// simplebus_sram_responder: SimpleBus SRAM responder with fixed latency; SIMPLEBUS_RAND_DELAY_EN adds 0..3 cycles of LFSR jitter
module simplebus_sram_responder
  import simplebus_pkg::*;
#(
  parameter logic [SB_ADDR_W-1:0] ADDR_BASE = SB_ADDR_BASE,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SB_ADDR_W-1:0] req_addr,
  input  logic                 req_wen,
  input  logic [SB_DATA_W-1:0] req_wdata,
  input  logic [SB_MASK_W-1:0] req_wmask,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [SB_DATA_W-1:0] resp_rdata,
  output logic                 resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  sb_state_e state, state_n;
  logic [4:0] cnt, cnt_n, eff;
  logic accept, acc;
  logic [SB_ADDR_W-1:0] l_addr, a_addr, off;
  logic [SB_DATA_W-1:0] l_wdata, a_wdata;
  logic [SB_MASK_W-1:0] l_wmask, a_wmask;
  logic l_wen, a_wen, in_range, unused_off;
  logic [AW-1:0] idx;
  logic [SB_DATA_W-1:0] mem [DEPTH_WORDS];
`ifdef SIMPLEBUS_RAND_DELAY_EN
  logic [15:0] lfsr;
  simplebus_lfsr16 u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
  assign eff = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
  assign eff = 5'(LATENCY);
`endif
  assign accept = state == IDLE && req_valid && req_ready;
  assign resp_valid = state == RESP;
  // zero-latency accesses happen on the accept edge, so use the live request fields then
  assign a_addr = state == IDLE ? req_addr : l_addr;
  assign a_wen = state == IDLE ? req_wen : l_wen;
  assign a_wdata = state == IDLE ? req_wdata : l_wdata;
  assign a_wmask = state == IDLE ? req_wmask : l_wmask;
  assign off = a_addr - ADDR_BASE;
  assign in_range = {2'b00, off[SB_ADDR_W-1:2]} < 32'(DEPTH_WORDS);
  assign idx = off[AW+1:2];
  assign unused_off = ^off[1:0];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    acc = 1'b0;
    case (state)
      IDLE: if (accept) begin
        acc = eff == 5'd0;
        state_n = acc ? RESP : WAIT;
        cnt_n = acc ? 5'd0 : eff - 5'd1;
      end
      WAIT: begin
        acc = cnt == 5'd0;
        state_n = acc ? RESP : WAIT;
        cnt_n = acc ? cnt : cnt - 5'd1;
      end
      RESP: state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      req_ready <= state_n == IDLE;
      if (acc) begin
        resp_rdata <= (!a_wen && in_range) ? mem[idx] : '0;
        resp_err <= !in_range;
      end
      if (accept) begin
        l_addr <= req_addr;
        l_wen <= req_wen;
        l_wdata <= req_wdata;
        l_wmask <= req_wmask;
      end
    end
  // storage is never reset; a reset edge suppresses any pending write
  always_ff @(posedge clk)
    if (rst && acc && a_wen && in_range)
      for (int i = 0; i < SB_MASK_W; i++)
        if (a_wmask[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
endmodule

// File: tb/tb_simplebus_sram_responder.sv
// tb_simplebus_sram_responder: directed vectors against LATENCY=2 and LATENCY=4 responders
module tb_simplebus_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v2 = 1'b0, v4 = 1'b0, rr2 = 1'b1, rr4 = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic wen = 1'b0;
  logic [3:0] wmask = '0;
  logic rdy2, rdy4, rv2, rv4, err2, err4;
  logic [31:0] rd2, rd4;
  logic sel = 1'b0;
  logic c_rdy, c_rv, c_err;
  logic [31:0] c_rd;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  simplebus_sram_responder #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_addr(addr),
    .req_wen(wen), .req_wdata(wdata), .req_wmask(wmask), .resp_valid(rv2),
    .resp_ready(rr2), .resp_rdata(rd2), .resp_err(err2));
  simplebus_sram_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_addr(addr),
    .req_wen(wen), .req_wdata(wdata), .req_wmask(wmask), .resp_valid(rv4),
    .resp_ready(rr4), .resp_rdata(rd4), .resp_err(err4));

  assign c_rdy = sel ? rdy4 : rdy2;
  assign c_rv = sel ? rv4 : rv2;
  assign c_rd = sel ? rd4 : rd2;
  assign c_err = sel ? err4 : err2;

  typedef struct {
    logic wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] mask;
    logic [31:0] exp_d;
    logic exp_e;
  } vec_t;
  vec_t vec [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic [31:0] exp_d, input logic exp_e,
                     input int exp_lat, input string nm);
    int k, n;
    sel = s;
    wen = w; addr = a; wdata = d; wmask = m;
    if (s) v4 = 1'b1; else v2 = 1'b1;
    k = 0;
    while (!c_rdy && k < 20) begin step(); k++; end
    chk({nm, " req_ready"}, {31'd0, c_rdy}, 32'd1);
    step();
    v2 = 1'b0; v4 = 1'b0;
    n = 0;
    while (!c_rv && n < 40) begin step(); n++; end
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " rdata"}, c_rd, exp_d);
    chk({nm, " err"}, {31'd0, c_err}, {31'd0, exp_e});
    step();
    chk({nm, " resp_valid drop"}, {31'd0, c_rv}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vec[1]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vec[2]  = '{1'b1, 32'h8000_0010, 32'h0000_0055, 4'b0001, 32'h0, 1'b0};
    vec[3]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BE55, 1'b0};
    vec[4]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0};
    vec[5]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BE55, 1'b0};
    vec[6]  = '{1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b1010, 32'h0, 1'b0};
    vec[7]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hAAAD_CC55, 1'b0};
    vec[8]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    vec[9]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
    vec[10] = '{1'b1, 32'h8000_4000, 32'h1111_1111, 4'hF, 32'h0, 1'b1};
    vec[11] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0};
    vec[12] = '{1'b1, 32'h8000_3FFC, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
    vec[13] = '{1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0};

    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset req_ready", {31'd0, rdy2}, 32'd0);
      chk("reset resp_valid", {31'd0, rv2}, 32'd0);
    end
    rst = 1'b1;
    step();
    chk("post-reset req_ready", {31'd0, rdy2}, 32'd1);
    chk("post-reset resp_valid", {31'd0, rv2}, 32'd0);

    for (int i = 0; i < 14; i++)
      txn(1'b0, vec[i].wen, vec[i].addr, vec[i].wdata, vec[i].mask, vec[i].exp_d, vec[i].exp_e, 2,
          $sformatf("vec%0d", i));

    begin : backpressure
      int n;
      sel = 1'b0; rr2 = 1'b0;
      wen = 1'b0; addr = 32'h8000_0010; v2 = 1'b1;
      n = 0;
      while (!rdy2 && n < 20) begin step(); n++; end
      step();
      v2 = 1'b0;
      n = 0;
      while (!rv2 && n < 40) begin step(); n++; end
      chk("bp latency", n, 2);
      for (int i = 0; i < 5; i++) begin
        step();
        chk("bp resp_valid", {31'd0, rv2}, 32'd1);
        chk("bp rdata", rd2, 32'hAAAD_CC55);
        chk("bp err", {31'd0, err2}, 32'd0);
        chk("bp req_ready", {31'd0, rdy2}, 32'd0);
      end
      rr2 = 1'b1;
      step();
      chk("bp resp_valid drop", {31'd0, rv2}, 32'd0);
    end

    txn(1'b1, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 4, "l4 init write");

    begin : reset_mid_wait
      int n;
      sel = 1'b1;
      wen = 1'b1; addr = 32'h8000_0020; wdata = 32'h1234_5678; wmask = 4'hF; v4 = 1'b1;
      n = 0;
      while (!rdy4 && n < 20) begin step(); n++; end
      step();
      v4 = 1'b0;
      step();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
        step();
        chk("rst-wait no resp", {31'd0, rv4}, 32'd0);
      end
    end

    txn(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 4, "l4 read after reset");
    txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 2, "l2 read after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
